// File: rtl/program_counter_unit.sv
// program_counter_unit: PC register with sequential advance, redirects, trap entry/return
// and lockup on a nested fault. Misaligned redirects become precise traps.
module program_counter_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h10),
   parameter bit              COMPRESSED   = 1'b0
) (
   input  logic            clock,
   input  logic            reset,
   output logic [XLEN-1:0] pcOfInstruction,
   output logic [XLEN-1:0] nextSequentialPC,
   input  logic            advance,
   input  logic            instructionIsCompressed,
   input  logic            redirectEnable,
   input  logic [XLEN-1:0] redirectTarget,
   input  logic            trapRequest,
   input  logic            trapReturn,
   output logic [XLEN-1:0] exceptionPC,
   output logic [XLEN-1:0] badTarget,
   output logic [1:0]      trapCause,
   output logic            inHandler,
   output logic            programCounterMisaligned,
   output logic            lockedUp
);
   localparam int ALIGN_BITS = COMPRESSED ? 1 : 2;
   typedef enum logic [1:0] {RUN, HANDLER, LOCKUP} state_e;
   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, exc_q, exc_d, bad_q, bad_d;
   logic [1:0]      cause_q, cause_d;
   logic            mis_q, mis_d;
   logic            misaligned, fault;
   assign misaligned       = redirectTarget[ALIGN_BITS-1:0] != '0;
   assign fault            = trapRequest | (redirectEnable & misaligned);
   assign nextSequentialPC = pc_q + ((COMPRESSED && instructionIsCompressed) ? XLEN'(2) : XLEN'(4));
   assign pcOfInstruction  = pc_q;
   assign exceptionPC      = exc_q;
   assign badTarget        = bad_q;
   assign trapCause        = cause_q;
   assign programCounterMisaligned = mis_q;
   assign inHandler        = state_q == HANDLER;
   assign lockedUp         = state_q == LOCKUP;
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      exc_d   = exc_q;
      bad_d   = bad_q;
      cause_d = cause_q;
      mis_d   = mis_q;
      if (state_q != LOCKUP) begin
         if (fault) begin
            if (state_q == RUN) begin
               state_d = HANDLER;
               exc_d   = pc_q;
               pc_d    = TRAP_VECTOR;
               cause_d = trapRequest ? 2'b01 : 2'b10;
               bad_d   = trapRequest ? bad_q : redirectTarget;
               mis_d   = trapRequest ? mis_q : 1'b1;
            end else begin
               state_d = LOCKUP;
            end
         end else if (trapReturn && state_q == HANDLER) begin
            state_d = RUN;
            pc_d    = exc_q;
            mis_d   = 1'b0;
         end else begin
            pc_d = redirectEnable ? redirectTarget : advance ? nextSequentialPC : pc_q;
         end
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RUN;
         pc_q    <= RESET_VECTOR;
         exc_q   <= '0;
         bad_q   <= '0;
         cause_q <= 2'b00;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         exc_q   <= exc_d;
         bad_q   <= bad_d;
         cause_q <= cause_d;
         mis_q   <= mis_d;
      end
   end
endmodule

// File: tb/tb_program_counter_unit.sv
// tb_program_counter_unit: three builds (32-bit 4-byte, 32-bit compressed, 16-bit compressed)
// driven in lockstep and checked against an arithmetic model, plus directed vectors.
module tb_program_counter_unit;
   logic        clk = 1'b0;
   logic        rst, adv, cmp, re, trq, rt;
   logic [31:0] tgt;
   logic [31:0] pc0, nsp0, exc0, bad0, pc1, nsp1, exc1, bad1;
   logic [15:0] pc2, nsp2, exc2, bad2;
   logic [1:0]  cause0, cause1, cause2;
   logic        inh0, inh1, inh2, mis0, mis1, mis2, lock0, lock1, lock2;
   int          nvec = 0, nerr = 0;

   always #5 clk = ~clk;

   program_counter_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h10), .COMPRESSED(1'b0)) d0 (
      .clock(clk), .reset(rst), .pcOfInstruction(pc0), .nextSequentialPC(nsp0), .advance(adv),
      .instructionIsCompressed(cmp), .redirectEnable(re), .redirectTarget(tgt), .trapRequest(trq),
      .trapReturn(rt), .exceptionPC(exc0), .badTarget(bad0), .trapCause(cause0), .inHandler(inh0),
      .programCounterMisaligned(mis0), .lockedUp(lock0));
   program_counter_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h10), .COMPRESSED(1'b1)) d1 (
      .clock(clk), .reset(rst), .pcOfInstruction(pc1), .nextSequentialPC(nsp1), .advance(adv),
      .instructionIsCompressed(cmp), .redirectEnable(re), .redirectTarget(tgt), .trapRequest(trq),
      .trapReturn(rt), .exceptionPC(exc1), .badTarget(bad1), .trapCause(cause1), .inHandler(inh1),
      .programCounterMisaligned(mis1), .lockedUp(lock1));
   program_counter_unit #(.XLEN(16), .RESET_VECTOR(16'h0), .TRAP_VECTOR(16'h10), .COMPRESSED(1'b1)) d2 (
      .clock(clk), .reset(rst), .pcOfInstruction(pc2), .nextSequentialPC(nsp2), .advance(adv),
      .instructionIsCompressed(cmp), .redirectEnable(re), .redirectTarget(tgt[15:0]), .trapRequest(trq),
      .trapReturn(rt), .exceptionPC(exc2), .badTarget(bad2), .trapCause(cause2), .inHandler(inh2),
      .programCounterMisaligned(mis2), .lockedUp(lock2));

   typedef struct packed {
      logic [63:0] pc, nsp, exc, bad;
      logic [1:0]  cause;
      logic        inh, mis, lock;
   } obs_t;
   typedef struct {
      longint pc, exc, bad;
      int     cause, mode;
      bit     mis;
   } mstate_t;
   typedef struct {
      bit          r, a, c, e, tq, rt;
      logic [31:0] t;
      obs_t        exp;
   } vec_t;

   mstate_t m[3];
   int      xl_of[3] = '{32, 32, 16};
   bit      cp_of[3] = '{1'b0, 1'b1, 1'b1};

   // mode: 0 running, 1 in handler, 2 locked up
   function automatic mstate_t step(mstate_t s, int xl, bit cp, bit r, bit a, bit c, bit e,
                                    longint t_in, bit tq, bit ret);
      longint mdl = longint'(64'd1 << xl);
      longint t   = t_in % mdl;
      bit     bad_redirect = e && (t % (cp ? 2 : 4) != 0);
      if (r) begin
         s = '{pc: 0, exc: 0, bad: 0, cause: 0, mode: 0, mis: 0};
         return s;
      end
      if (s.mode == 2) return s;
      if (tq || bad_redirect) begin
         if (s.mode == 1) begin
            s.mode = 2;
            return s;
         end
         s.exc = s.pc; s.pc = 16; s.mode = 1; s.cause = tq ? 1 : 2;
         if (!tq) begin
            s.bad = t; s.mis = 1;
         end
         return s;
      end
      if (ret && s.mode == 1) begin
         s.pc = s.exc; s.mode = 0; s.mis = 0;
      end else if (e) s.pc = t;
      else if (a) s.pc = (s.pc + ((cp && c) ? 2 : 4)) % mdl;
      return s;
   endfunction

   function automatic obs_t model_obs(int i);
      obs_t   o;
      longint mdl = longint'(64'd1 << xl_of[i]);
      o.pc    = 64'(m[i].pc);
      o.nsp   = 64'((m[i].pc + ((cp_of[i] && cmp) ? 2 : 4)) % mdl);
      o.exc   = 64'(m[i].exc);
      o.bad   = 64'(m[i].bad);
      o.cause = 2'(m[i].cause);
      o.inh   = m[i].mode == 1;
      o.mis   = m[i].mis;
      o.lock  = m[i].mode == 2;
      return o;
   endfunction

   function automatic obs_t dut_obs(int i);
      obs_t o;
      o.pc    = i == 0 ? 64'(pc0)  : i == 1 ? 64'(pc1)  : 64'(pc2);
      o.nsp   = i == 0 ? 64'(nsp0) : i == 1 ? 64'(nsp1) : 64'(nsp2);
      o.exc   = i == 0 ? 64'(exc0) : i == 1 ? 64'(exc1) : 64'(exc2);
      o.bad   = i == 0 ? 64'(bad0) : i == 1 ? 64'(bad1) : 64'(bad2);
      o.cause = i == 0 ? cause0 : i == 1 ? cause1 : cause2;
      o.inh   = i == 0 ? inh0  : i == 1 ? inh1  : inh2;
      o.mis   = i == 0 ? mis0  : i == 1 ? mis1  : mis2;
      o.lock  = i == 0 ? lock0 : i == 1 ? lock1 : lock2;
      return o;
   endfunction

   task automatic cmp_obs(string name, int i, obs_t got, obs_t exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s dut%0d got pc=%h nsp=%h exc=%h bad=%h cause=%b inh=%b mis=%b lock=%b; exp pc=%h nsp=%h exc=%h bad=%h cause=%b inh=%b mis=%b lock=%b",
                  name, i, got.pc, got.nsp, got.exc, got.bad, got.cause, got.inh, got.mis, got.lock,
                  exp.pc, exp.nsp, exp.exc, exp.bad, exp.cause, exp.inh, exp.mis, exp.lock);
      end
   endtask

   task automatic chk(string name, longint got, longint exp);
      nvec++;
      if (got != exp) begin
         nerr++;
         $display("FAIL %s got %h exp %h", name, got, exp);
      end
   endtask

   task automatic cycle(bit r, bit a, bit c, bit e, logic [31:0] t, bit tq, bit ret);
      rst = r; adv = a; cmp = c; re = e; tgt = t; trq = tq; rt = ret;
      @(posedge clk);
      for (int i = 0; i < 3; i++) m[i] = step(m[i], xl_of[i], cp_of[i], r, a, c, e, longint'(t), tq, ret);
      #1;
      for (int i = 0; i < 3; i++) cmp_obs("model", i, dut_obs(i), model_obs(i));
   endtask

   function automatic vec_t mk(bit r, bit a, bit e, logic [31:0] t, bit tq, bit ret,
                               logic [31:0] pc, logic [31:0] exc, logic [31:0] bad,
                               logic [1:0] cause, bit inh, bit mis, bit lock);
      vec_t v;
      v.r = r; v.a = a; v.c = 1'b0; v.e = e; v.t = t; v.tq = tq; v.rt = ret;
      v.exp = '{pc: 64'(pc), nsp: 64'(pc + 32'd4), exc: 64'(exc), bad: 64'(bad),
                cause: cause, inh: inh, mis: mis, lock: lock};
      return v;
   endfunction

   initial begin
      vec_t tbl[13];
      obs_t rst_obs = '{pc: 64'h0, nsp: 64'h4, exc: 64'h0, bad: 64'h0, cause: 2'b00, inh: 1'b0, mis: 1'b0, lock: 1'b0};
      //           r  a  e  tgt           tq rt  pc          exc         bad    cause inh mis lock
      tbl[0]  = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h0,  2'b00, 0, 0, 0);
      tbl[1]  = mk(0, 1, 0, 32'h0,        0, 0, 32'h4,  32'h0,  32'h0,  2'b00, 0, 0, 0);
      tbl[2]  = mk(0, 1, 0, 32'h0,        0, 0, 32'h8,  32'h0,  32'h0,  2'b00, 0, 0, 0);
      tbl[3]  = mk(0, 1, 0, 32'h0,        0, 0, 32'hC,  32'h0,  32'h0,  2'b00, 0, 0, 0);
      tbl[4]  = mk(0, 0, 1, 32'h40,       0, 0, 32'h40, 32'h0,  32'h0,  2'b00, 0, 0, 0);
      tbl[5]  = mk(0, 0, 1, 32'h22,       0, 0, 32'h10, 32'h40, 32'h22, 2'b10, 1, 1, 0);
      tbl[6]  = mk(0, 0, 0, 32'h0,        0, 1, 32'h40, 32'h40, 32'h22, 2'b10, 0, 0, 0);
      tbl[7]  = mk(0, 0, 1, 32'h80,       0, 0, 32'h80, 32'h40, 32'h22, 2'b10, 0, 0, 0);
      tbl[8]  = mk(0, 1, 1, 32'h200,      1, 0, 32'h10, 32'h80, 32'h22, 2'b01, 1, 0, 0);
      tbl[9]  = mk(0, 0, 0, 32'h0,        0, 1, 32'h80, 32'h80, 32'h22, 2'b01, 0, 0, 0);
      tbl[10] = mk(0, 1, 0, 32'h0,        0, 1, 32'h84, 32'h80, 32'h22, 2'b01, 0, 0, 0);
      tbl[11] = mk(0, 0, 0, 32'h0,        1, 0, 32'h10, 32'h84, 32'h22, 2'b01, 1, 0, 0);
      tbl[12] = mk(0, 0, 0, 32'h0,        1, 0, 32'h10, 32'h84, 32'h22, 2'b01, 0, 0, 1);
      foreach (m[i]) m[i] = '{pc: 0, exc: 0, bad: 0, cause: 0, mode: 0, mis: 0};
      rst = 1'b1; adv = 1'b0; cmp = 1'b0; re = 1'b0; tgt = '0; trq = 1'b0; rt = 1'b0;
      for (int k = 0; k < 13; k++) begin
         cycle(tbl[k].r, tbl[k].a, tbl[k].c, tbl[k].e, tbl[k].t, tbl[k].tq, tbl[k].rt);
         cmp_obs($sformatf("vec%0d", k), 0, dut_obs(0), tbl[k].exp);
      end
      // locked up: nothing but reset may move the core
      for (int k = 0; k < 10; k++) begin
         cycle(0, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 32'h300, 0, 1'($urandom_range(0, 1)));
         cmp_obs("lockup_hold", 0, dut_obs(0), tbl[12].exp);
      end
      cycle(1, 1, 0, 1, 32'h300, 1, 1);
      cmp_obs("lockup_reset", 0, dut_obs(0), rst_obs);
      cycle(0, 0, 0, 1, 32'h100, 0, 0);
      cycle(0, 1, 1, 0, 32'h0, 0, 0);
      chk("c1_step2", longint'(pc1), 64'h102);
      chk("c0_step4", longint'(pc0), 64'h104);
      cycle(0, 1, 0, 0, 32'h0, 0, 0);
      chk("c1_step4", longint'(pc1), 64'h106);
      chk("c0_step4b", longint'(pc0), 64'h108);
      cycle(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
      cycle(0, 1, 0, 0, 32'h0, 0, 0);
      chk("wrap32_pc", longint'(pc0), 64'h0);
      chk("wrap32_noflag", longint'({cause0, mis0, inh0, lock0}), 64'h0);
      chk("wrap16_pc4", longint'(pc2), 64'h0);
      cycle(1, 0, 0, 0, 32'h0, 0, 0);
      cycle(0, 0, 0, 1, 32'h0000_FFFE, 0, 0);
      cycle(0, 1, 1, 0, 32'h0, 0, 0);
      chk("wrap16_pc2", longint'(pc2), 64'h0);
      chk("wrap16_noflag", longint'({cause2, mis2, inh2, lock2}), 64'h0);
      cycle(1, 0, 0, 0, 32'h0, 0, 0);
      for (int k = 0; k < 3000; k++) begin
         logic [31:0] t;
         case ($urandom_range(0, 7))
            0:       t = $urandom;
            1:       t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            2:       t = 32'($urandom_range(0, 65535)) | 32'h2;
            default: t = $urandom & ~32'h3;
         endcase
         cycle($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3) == 0, t, $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
